// File: rtl/dlx_mem_arb_pkg.sv
// Shared types, default parameters and the round-robin index helper for the
// DLX memory port arbiter.
package dlx_mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_WAIT = 2'b01,
    ARB_DONE = 2'b10
  } arb_state_t;

  typedef enum logic [1:0] {
    ACC_WORD = 2'b00,
    ACC_BYTE = 2'b01,
    ACC_HALF = 2'b10
  } acc_size_t;

  localparam int DEF_NUM_REQ        = 2;
  localparam int DEF_WORD_SIZE      = 32;
  localparam int DEF_ADDRESS_SIZE   = 16;
  localparam int DEF_TIMEOUT_CYCLES = 64;
  localparam int MAX_REQ            = 4;
  localparam int IDX_W              = 2;

  // Index of the requester 'off' positions after 'last', wrapping at nreq.
  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] last,
                                                input logic [2:0]       off,
                                                input logic [2:0]       nreq);
    logic [2:0] sum;
    sum = {1'b0, last} + off;
    if (sum >= nreq) begin
      rr_index = IDX_W'(sum - nreq);
    end else begin
      rr_index = IDX_W'(sum);
    end
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant wins.
module rr_arbiter
  import dlx_mem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  localparam logic [2:0] NREQ3 = 3'(NUM_REQ);

  logic [MAX_REQ-1:0] req_pad_s;
  logic               found_s;

  assign req_pad_s = MAX_REQ'(req);

  // Scan forward from last_grant+1 and keep the first active index.
  always_comb begin
    logic [IDX_W-1:0] idx_v;
    grant_idx = {IDX_W{1'b0}};
    found_s   = 1'b0;
    idx_v     = {IDX_W{1'b0}};
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx_v = rr_index(last_grant, 3'(off), NREQ3);
      if (!found_s && req_pad_s[idx_v]) begin
        grant_idx = idx_v;
        found_s   = 1'b1;
      end else begin
      end
    end
  end

  // Expand the winning index to a one-hot grant.
  always_comb begin
    grant = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = found_s && (grant_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one ENABLE/READNOTWRITE/DATA_READY memory port.
// Optional WAIT watchdog enabled by defining DLX_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import dlx_mem_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int WORD_SIZE      = DEF_WORD_SIZE,
  parameter int ADDRESS_SIZE   = DEF_ADDRESS_SIZE,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_rnw,
  input  logic [NUM_REQ*ADDRESS_SIZE-1:0] req_addr,
  input  logic [NUM_REQ*WORD_SIZE-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [WORD_SIZE-1:0]            rsp_rdata,
  output logic                            rsp_err,
  output logic                            mem_enable,
  output logic                            mem_readnotwrite,
  output logic [ADDRESS_SIZE-1:0]         mem_address,
  output logic [WORD_SIZE-1:0]            mem_wdata,
  input  logic [WORD_SIZE-1:0]            mem_rdata,
  input  logic                            mem_data_ready
);

  arb_state_t               state_q, state_d;
  logic [IDX_W-1:0]         last_grant_q, last_grant_d;
  logic [IDX_W-1:0]         win_q, win_d;
  logic                     rnw_q, rnw_d;
  logic [ADDRESS_SIZE-1:0]  addr_q, addr_d;
  logic [WORD_SIZE-1:0]     wdata_q, wdata_d;
  logic [WORD_SIZE-1:0]     rdata_q, rdata_d;
  logic                     mem_enable_q, mem_enable_d;
  logic [NUM_REQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0]       grant_s, req_ready_s, win_oh_s;
  logic [IDX_W-1:0]         grant_idx_s;
  logic                     sel_rnw_s;
  logic [ADDRESS_SIZE-1:0]  sel_addr_s;
  logic [WORD_SIZE-1:0]     sel_wdata_s;

`ifdef DLX_ARB_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             err_q, err_d;
`else
  logic unused_tmo_s;
  assign unused_tmo_s = (TIMEOUT_CYCLES > 0);
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant_s),
    .grant_idx  (grant_idx_s)
  );

  // One-hot AND-OR mux of the granted requester's command fields.
  always_comb begin
    sel_rnw_s   = 1'b0;
    sel_addr_s  = {ADDRESS_SIZE{1'b0}};
    sel_wdata_s = {WORD_SIZE{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_rnw_s   = sel_rnw_s | (req_rnw[i] & grant_s[i]);
      sel_addr_s  = sel_addr_s | (req_addr[i*ADDRESS_SIZE +: ADDRESS_SIZE] & {ADDRESS_SIZE{grant_s[i]}});
      sel_wdata_s = sel_wdata_s | (req_wdata[i*WORD_SIZE +: WORD_SIZE] & {WORD_SIZE{grant_s[i]}});
    end
  end

  // Decode the latched winner for the response pulse.
  always_comb begin
    win_oh_s = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      win_oh_s[i] = (win_q == IDX_W'(i));
    end
  end

  // Next-state and command/response computation.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    win_d        = win_q;
    rnw_d        = rnw_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    mem_enable_d = 1'b0;
    rsp_valid_d  = {NUM_REQ{1'b0}};
    req_ready_s  = {NUM_REQ{1'b0}};
`ifdef DLX_ARB_TIMEOUT_EN
    timer_d      = {TMR_W{1'b0}};
    err_d        = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (|req_valid) begin
          req_ready_s  = grant_s;
          win_d        = grant_idx_s;
          last_grant_d = grant_idx_s;
          rnw_d        = sel_rnw_s;
          addr_d       = sel_addr_s;
          wdata_d      = sel_wdata_s;
          mem_enable_d = 1'b1;
          state_d      = ARB_WAIT;
        end else begin
          state_d      = ARB_IDLE;
        end
      end
      ARB_WAIT: begin
        mem_enable_d = 1'b1;
        if (mem_data_ready) begin
          rdata_d      = rnw_q ? mem_rdata : {WORD_SIZE{1'b0}};
          rsp_valid_d  = win_oh_s;
          mem_enable_d = 1'b0;
          state_d      = ARB_DONE;
        end else begin
`ifdef DLX_ARB_TIMEOUT_EN
          if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            rdata_d      = {WORD_SIZE{1'b0}};
            err_d        = 1'b1;
            rsp_valid_d  = win_oh_s;
            mem_enable_d = 1'b0;
            state_d      = ARB_DONE;
          end else begin
            timer_d      = timer_q + 1'b1;
          end
`else
          state_d = ARB_WAIT;
`endif
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      win_q        <= {IDX_W{1'b0}};
      rnw_q        <= 1'b0;
      addr_q       <= {ADDRESS_SIZE{1'b0}};
      wdata_q      <= {WORD_SIZE{1'b0}};
      rdata_q      <= {WORD_SIZE{1'b0}};
      mem_enable_q <= 1'b0;
      rsp_valid_q  <= {NUM_REQ{1'b0}};
`ifdef DLX_ARB_TIMEOUT_EN
      timer_q      <= {TMR_W{1'b0}};
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      win_q        <= win_d;
      rnw_q        <= rnw_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      mem_enable_q <= mem_enable_d;
      rsp_valid_q  <= rsp_valid_d;
`ifdef DLX_ARB_TIMEOUT_EN
      timer_q      <= timer_d;
      err_q        <= err_d;
`endif
    end
  end

  assign req_ready        = req_ready_s;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_rdata        = rdata_q;
  assign mem_enable       = mem_enable_q;
  assign mem_readnotwrite = rnw_q;
  assign mem_address      = addr_q;
  assign mem_wdata        = wdata_q;
`ifdef DLX_ARB_TIMEOUT_EN
  assign rsp_err          = err_q;
`else
  assign rsp_err          = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model plus
// directed scenarios with hand-computed expectations.
module tb_mem_port_arbiter;

  localparam int NR = 2;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_rnw = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*DW-1:0]  req_wdata = '0;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              mem_enable;
  logic              mem_readnotwrite;
  logic [AW-1:0]     mem_address;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata = 32'hBAD0_0BAD;
  logic              mem_data_ready = 1'b0;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          mem_delay = 2;
  logic [DW-1:0] mem_val = 32'h0;
  logic        stray_ready = 1'b0;
  int          wcnt = 0;
  int          en_total = 0;
  int          rsp_total = 0;

  // transaction-level model: 0 = free, 1 = access on the port, 2 = responding
  int            m_phase = 0;
  int            m_last = NR - 1;
  int            m_win = 0;
  int            m_cnt = 0;
  logic          m_rnw = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;
  logic          m_err = 1'b0;
  int            grants_q[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .NUM_REQ(NR), .WORD_SIZE(DW), .ADDRESS_SIZE(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rnw(req_rnw), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_enable(mem_enable), .mem_readnotwrite(mem_readnotwrite),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_data_ready(mem_data_ready)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (v[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] exp_ready();
    int w;
    w = pick(req_valid, m_last);
    if (m_phase == 0 && w >= 0) return NR'(1) << w;
    return '0;
  endfunction

  function automatic logic [NR-1:0] exp_rsp();
    if (m_phase == 2) return NR'(1) << m_win;
    return '0;
  endfunction

  // Model update on the same edges as the design.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_last  <= NR - 1;
      m_cnt   <= 0;
      m_err   <= 1'b0;
    end else begin
      case (m_phase)
        0: if (pick(req_valid, m_last) >= 0) begin
          m_win   <= pick(req_valid, m_last);
          m_last  <= pick(req_valid, m_last);
          m_rnw   <= req_rnw[pick(req_valid, m_last)];
          m_addr  <= req_addr[pick(req_valid, m_last)*AW +: AW];
          m_wdata <= req_wdata[pick(req_valid, m_last)*DW +: DW];
          m_cnt   <= 0;
          m_phase <= 1;
          grants_q.push_back(pick(req_valid, m_last));
        end
        1: if (mem_data_ready) begin
          m_rdata <= m_rnw ? mem_rdata : '0;
          m_err   <= 1'b0;
          m_phase <= 2;
        end else begin
          m_cnt <= m_cnt + 1;
`ifdef DLX_ARB_TIMEOUT_EN
          if (m_cnt + 1 == TO) begin
            m_rdata <= '0;
            m_err   <= 1'b1;
            m_phase <= 2;
          end
`endif
        end
        default: m_phase <= 0;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("req_ready", req_ready, exp_ready());
    chk("mem_enable", mem_enable, m_phase == 1);
    chk("rsp_valid", rsp_valid, exp_rsp());
    if (m_phase == 1) begin
      chk("mem_address", mem_address, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("mem_rnw", mem_readnotwrite, m_rnw);
    end
    if (m_phase == 2) begin
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_err", rsp_err, m_err);
    end
  end

  // Memory responder: DATA_READY mem_delay cycles into an access (0 = never).
  always @(negedge clk) begin
    if (mem_enable) begin
      wcnt <= wcnt + 1;
      if (mem_delay != 0 && wcnt + 1 == mem_delay) begin
        mem_data_ready <= 1'b1;
        mem_rdata      <= mem_val;
      end else begin
        mem_data_ready <= 1'b0;
        mem_rdata      <= 32'hBAD0_0BAD;
      end
    end else begin
      wcnt           <= 0;
      mem_data_ready <= stray_ready;
      mem_rdata      <= 32'hBAD0_0BAD;
    end
    en_total  <= en_total + int'(mem_enable);
    rsp_total <= rsp_total + int'(rsp_valid != '0);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic rnw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_rnw[i] = rnw;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic wait_rsp(input string nm, input int lim, output int cyc);
    bit got;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < lim) begin
      @(negedge clk);
      #1;
      cyc++;
      got = (rsp_valid != '0);
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: no rsp_valid within %0d cycles", nm, lim);
    end
  endtask

  initial begin
    int cyc;
    int base_rsp;
    int base_en;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_enable", mem_enable, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_mem_address", mem_address, 16'h0000);
    tick();
    rst = 1'b0;
    tick();

    // single read
    base_rsp = rsp_total;
    mem_delay = 2;
    mem_val = 32'hDEADBEEF;
    set_req(0, 1'b1, 16'h0010, 32'h0);
    tick();
    req_valid = '0;
    wait_rsp("t1", 20, cyc);
    chk("t1_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("t1_rsp_valid", rsp_valid, 2'b01);
    chk("t1_latency", cyc, 3);
    tick();
    tick();
    chk("t1_rsp_count", rsp_total - base_rsp, 1);

    // single write from requester 1
    mem_delay = 3;
    set_req(1, 1'b0, 16'h0022, 32'h0000ABCD);
    tick();
    req_valid = '0;
    @(negedge clk);
    #1;
    chk("t2_enable", mem_enable, 1'b1);
    chk("t2_rnw", mem_readnotwrite, 1'b0);
    chk("t2_wdata", mem_wdata, 32'h0000ABCD);
    chk("t2_addr", mem_address, 16'h0022);
    wait_rsp("t2", 20, cyc);
    chk("t2_rsp_valid", rsp_valid, 2'b10);
    chk("t2_rdata", rsp_rdata, 32'h0);
    tick();

    // contention: both continuously valid
    grants_q.delete();
    mem_delay = 1;
    mem_val = 32'h0BADCAFE;
    set_req(0, 1'b1, 16'h0100, 32'h0);
    set_req(1, 1'b1, 16'h0200, 32'h0);
    for (int n = 0; n < 4; n++) wait_rsp("t3", 20, cyc);
    tick();
    req_valid = '0;
    tick();
    tick();
    chk("t3_grant_count", grants_q.size(), 4);
    if (grants_q.size() == 4) begin
      chk("t3_grant0", grants_q[0], 0);
      chk("t3_grant1", grants_q[1], 1);
      chk("t3_grant2", grants_q[2], 0);
      chk("t3_grant3", grants_q[3], 1);
    end

    // command stability over a slow access
    base_rsp = rsp_total;
    base_en = en_total;
    mem_delay = 10;
    set_req(0, 1'b0, 16'h0100, 32'h12345678);
    tick();
    req_valid = '0;
    repeat (20) tick();
    chk("t4_rsp_count", rsp_total - base_rsp, 1);
    chk("t4_enable_cycles", en_total - base_en, 10);

    // DATA_READY outside an access is ignored
    base_rsp = rsp_total;
    stray_ready = 1'b1;
    repeat (3) tick();
    stray_ready = 1'b0;
    tick();
    chk("stray_rsp_count", rsp_total - base_rsp, 0);

    // reset in the middle of an access
    base_rsp = rsp_total;
    mem_delay = 20;
    set_req(1, 1'b1, 16'h0300, 32'h0);
    tick();
    req_valid = '0;
    repeat (2) tick();
    #1 rst = 1'b1;
    #1;
    chk("t5_async_enable", mem_enable, 1'b0);
    chk("t5_async_rsp", rsp_valid, 2'b00);
    repeat (2) tick();
    rst = 1'b0;
    grants_q.delete();
    mem_delay = 1;
    set_req(0, 1'b1, 16'h0400, 32'h0);
    set_req(1, 1'b1, 16'h0500, 32'h0);
    tick();
    req_valid = '0;
    wait_rsp("t5", 20, cyc);
    chk("t5_rsp_valid", rsp_valid, 2'b01);
    chk("t5_first_grant", grants_q.size() > 0 ? grants_q[0] : -1, 0);
    tick();
    chk("t5_rsp_count", rsp_total - base_rsp, 1);

`ifdef DLX_ARB_TIMEOUT_EN
    // watchdog on a memory that never answers
    base_en = en_total;
    mem_delay = 0;
    set_req(0, 1'b1, 16'h0600, 32'h0);
    tick();
    req_valid = '0;
    wait_rsp("t6", 30, cyc);
    chk("t6_rsp_valid", rsp_valid, 2'b01);
    chk("t6_rsp_err", rsp_err, 1'b1);
    chk("t6_rdata", rsp_rdata, 32'h0);
    chk("t6_enable_cycles", en_total - base_en, 8);
    tick();
`endif

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
